da_table_reader: RTL and testbench

//  Consumer of the 8-entry distributed-arithmetic partial-sum table (A1..A8) built by the input-table

---
 rtl/da_table_reader_if.sv | 34 +++
 rtl/da_table_reader.sv | 138 +++++++++++++
 tb/tb_da_table_reader.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/da_table_reader_if.sv
// Bus bundle between the DA table generator/LMS control and the table reader:
// start request, 4-tap sample window, 8-entry partial-sum table, and result handshake.
interface da_table_reader_if #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned TBL_W  = 10,
  parameter int unsigned ACC_W  = 20
);
  logic              start;
  logic [N_BITS-1:0] x0;
  logic [N_BITS-1:0] x1;
  logic [N_BITS-1:0] x2;
  logic [N_BITS-1:0] x3;
  logic [TBL_W-1:0]  A1;
  logic [TBL_W-1:0]  A2;
  logic [TBL_W-1:0]  A3;
  logic [TBL_W-1:0]  A4;
  logic [TBL_W-1:0]  A5;
  logic [TBL_W-1:0]  A6;
  logic [TBL_W-1:0]  A7;
  logic [TBL_W-1:0]  A8;
  logic              busy;
  logic              valid;
  logic [ACC_W-1:0]  y;

  modport master (
    output start, x0, x1, x2, x3, A1, A2, A3, A4, A5, A6, A7, A8,
    input  busy, valid, y
  );

  modport slave (
    input  start, x0, x1, x2, x3, A1, A2, A3, A4, A5, A6, A7, A8,
    output busy, valid, y
  );
endinterface

// File: rtl/da_table_reader.sv
// Bit-serial distributed-arithmetic reader: shifts a 4-tap window LSB first, looks up
// offset-binary addressed partial sums and shift-accumulates them into one result per N_BITS+1 clocks.
module da_table_reader #(
  parameter int unsigned N_BITS = 8,
  parameter int unsigned TBL_W  = 10,
  parameter int unsigned ACC_W  = 20
) (
  input  logic            clk,
  input  logic            r,
  da_table_reader_if.slave bus
);

  localparam int unsigned CNT_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [N_BITS-1:0] sr0_q, sr0_d;
  logic [N_BITS-1:0] sr1_q, sr1_d;
  logic [N_BITS-1:0] sr2_q, sr2_d;
  logic [N_BITS-1:0] sr3_q, sr3_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ACC_W-1:0]  y_q, y_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic                     last_c;
  logic                     sgn_c;
  logic [2:0]               addr_c;
  logic signed [TBL_W-1:0]  tsel_c;
  logic [ACC_W-1:0]         ext_c;
  logic [ACC_W-1:0]         term_c;
  logic [ACC_W-1:0]         shifted_c;
  logic [ACC_W-1:0]         acc_step_c;

  // Offset-binary address: taps 1..3 relative to tap 0, tap 0 selects negation.
  assign sgn_c  = sr0_q[0];
  assign addr_c = {sr1_q[0] ^ sr0_q[0], sr2_q[0] ^ sr0_q[0], sr3_q[0] ^ sr0_q[0]};
  assign last_c = (cnt_q == CNT_W'(N_BITS - 1));

  always_comb begin
    tsel_c = bus.A1;
    case (addr_c)
      3'd0:    tsel_c = bus.A1;
      3'd1:    tsel_c = bus.A2;
      3'd2:    tsel_c = bus.A3;
      3'd3:    tsel_c = bus.A4;
      3'd4:    tsel_c = bus.A5;
      3'd5:    tsel_c = bus.A6;
      3'd6:    tsel_c = bus.A7;
      default: tsel_c = bus.A8;
    endcase
  end

  // The sign-bit weight is negative, so the final term is subtracted.
  always_comb begin
    ext_c      = ACC_W'(tsel_c);
    term_c     = sgn_c ? (ACC_W'(0) - ext_c) : ext_c;
    shifted_c  = term_c << cnt_q;
    acc_step_c = last_c ? (acc_q - shifted_c) : (acc_q + shifted_c);
  end

  always_comb begin
    state_d = state_q;
    sr0_d   = sr0_q;
    sr1_d   = sr1_q;
    sr2_d   = sr2_q;
    sr3_d   = sr3_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d = S_RUN;
          sr0_d   = bus.x0;
          sr1_d   = bus.x1;
          sr2_d   = bus.x2;
          sr3_d   = bus.x3;
          acc_d   = '0;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_step_c;
        sr0_d = sr0_q >> 1;
        sr1_d = sr1_q >> 1;
        sr2_d = sr2_q >> 1;
        sr3_d = sr3_q >> 1;
        cnt_d = cnt_q + CNT_W'(1);
        if (last_c) begin
          state_d = S_DONE;
          y_d     = acc_step_c;
          cnt_d   = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d  = (state_d == S_RUN);
    valid_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_q <= S_IDLE;
      sr0_q   <= '0;
      sr1_q   <= '0;
      sr2_q   <= '0;
      sr3_q   <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr0_q   <= sr0_d;
      sr1_q   <= sr1_d;
      sr2_q   <= sr2_d;
      sr3_q   <= sr3_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
    end
  end

  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.y     = y_q;

endmodule

// File: tb/tb_da_table_reader.sv
// Directed bench for da_table_reader: hand-computed DA results, latency, back-to-back and reset abort.
module tb_da_table_reader;

  localparam int unsigned N_BITS = 8;
  localparam int unsigned TBL_W  = 10;
  localparam int unsigned ACC_W  = 20;

  localparam logic [ACC_W-1:0] Y_NEG5    = ACC_W'(-5);
  localparam logic [ACC_W-1:0] Y_POS3    = ACC_W'(3);
  localparam logic [ACC_W-1:0] Y_POS10   = ACC_W'(10);
  localparam logic [ACC_W-1:0] Y_NEG1280 = ACC_W'(-1280);

  logic clk = 1'b0;
  logic r   = 1'b1;
  int   passed = 0;
  int   total  = 0;

  always #5 clk = ~clk;

  da_table_reader_if #(.N_BITS(N_BITS), .TBL_W(TBL_W), .ACC_W(ACC_W)) bus ();

  da_table_reader #(.N_BITS(N_BITS), .TBL_W(TBL_W), .ACC_W(ACC_W)) dut (
    .clk (clk),
    .r   (r),
    .bus (bus)
  );

  task automatic clear_inputs();
    bus.start = 1'b0;
    bus.x0 = '0; bus.x1 = '0; bus.x2 = '0; bus.x3 = '0;
    bus.A1 = '0; bus.A2 = '0; bus.A3 = '0; bus.A4 = '0;
    bus.A5 = '0; bus.A6 = '0; bus.A7 = '0; bus.A8 = '0;
  endtask

  // Issue one start and watch 14 cycles; lat is the cycle index of the first valid.
  task automatic run_conv(output int busy_n, output int valid_n, output int lat,
                          output logic [ACC_W-1:0] y_seen);
    busy_n = 0; valid_n = 0; lat = -1; y_seen = '0;
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bus.busy) busy_n++;
      if (bus.valid) begin
        valid_n++;
        if (lat < 0) begin
          lat = i;
          y_seen = bus.y;
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    #1 r = 1'b0;
    repeat (2) @(negedge clk);
    total++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", bus.valid); else passed++;
    total++; if (bus.y !== '0) $display("FAIL reset_y: got %h expected 0", bus.y); else passed++;
    @(negedge clk); r = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_zero_window();
    int bn, vn, lat; logic [ACC_W-1:0] ys;
    clear_inputs(); bus.A1 = TBL_W'(5);
    run_conv(bn, vn, lat, ys);
    total++; if (bn !== 8) $display("FAIL zero_busy_cycles: got %0d expected 8", bn); else passed++;
    total++; if (vn !== 1) $display("FAIL zero_valid_cycles: got %0d expected 1", vn); else passed++;
    total++; if (lat !== 9) $display("FAIL zero_latency: got %0d expected 9", lat); else passed++;
    total++; if (ys !== Y_NEG5) $display("FAIL zero_y: got %0d expected -5", $signed(ys)); else passed++;
    total++; if (bus.y !== Y_NEG5) $display("FAIL zero_y_held: got %0d expected -5", $signed(bus.y)); else passed++;
  endtask

  task automatic test_sign_tap();
    int bn, vn, lat; logic [ACC_W-1:0] ys;
    clear_inputs(); bus.x0 = 8'hFF; bus.A8 = TBL_W'(3);
    run_conv(bn, vn, lat, ys);
    total++; if (ys !== Y_POS3) $display("FAIL sign_tap_y: got %0d expected 3", $signed(ys)); else passed++;
    total++; if (lat !== 9) $display("FAIL sign_tap_latency: got %0d expected 9", lat); else passed++;
  endtask

  task automatic test_bit0_addr();
    int bn, vn, lat; logic [ACC_W-1:0] ys;
    clear_inputs(); bus.x1 = 8'h01; bus.A5 = TBL_W'(10);
    run_conv(bn, vn, lat, ys);
    total++; if (ys !== Y_POS10) $display("FAIL bit0_addr_y: got %0d expected 10", $signed(ys)); else passed++;
  endtask

  task automatic test_sign_bit();
    int bn, vn, lat; logic [ACC_W-1:0] ys;
    clear_inputs(); bus.x1 = 8'h80; bus.A5 = TBL_W'(10);
    run_conv(bn, vn, lat, ys);
    total++; if (ys !== Y_NEG1280) $display("FAIL sign_bit_y: got %0d expected -1280", $signed(ys)); else passed++;
  endtask

  task automatic test_start_in_run();
    int vn, lat; logic [ACC_W-1:0] ys;
    vn = 0; lat = -1; ys = '0;
    clear_inputs(); bus.A1 = TBL_W'(5);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        vn++;
        if (lat < 0) begin lat = i; ys = bus.y; end
      end
      bus.start = (i == 3 || i == 6);
      if (i == 3) bus.x0 = 8'hFF;
    end
    total++; if (lat !== 9) $display("FAIL run_start_latency: got %0d expected 9", lat); else passed++;
    total++; if (vn !== 1) $display("FAIL run_start_valids: got %0d expected 1", vn); else passed++;
    total++; if (ys !== Y_NEG5) $display("FAIL run_start_y: got %0d expected -5", $signed(ys)); else passed++;
  endtask

  task automatic test_back_to_back();
    int v1, v2, vn; logic [ACC_W-1:0] y1, y2;
    v1 = -1; v2 = -1; vn = 0; y1 = '0; y2 = '0;
    clear_inputs(); bus.x1 = 8'h01; bus.A5 = TBL_W'(10);
    @(negedge clk); bus.start = 1'b1;
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        vn++;
        if (v1 < 0) begin v1 = i; y1 = bus.y; end
        else if (v2 < 0) begin v2 = i; y2 = bus.y; end
      end
      if (i == 9) bus.x1 = 8'h80;
      if (i == 18) bus.start = 1'b0;
    end
    total++; if (v1 !== 9) $display("FAIL b2b_first_valid: got %0d expected 9", v1); else passed++;
    total++; if (v2 - v1 !== 9) $display("FAIL b2b_spacing: got %0d expected 9", v2 - v1); else passed++;
    total++; if (vn !== 2) $display("FAIL b2b_valid_count: got %0d expected 2", vn); else passed++;
    total++; if (y1 !== Y_POS10) $display("FAIL b2b_y1: got %0d expected 10", $signed(y1)); else passed++;
    total++; if (y2 !== Y_NEG1280) $display("FAIL b2b_y2: got %0d expected -1280", $signed(y2)); else passed++;
  endtask

  task automatic test_reset_abort();
    int bn, vn, lat; logic [ACC_W-1:0] ys;
    clear_inputs(); bus.A1 = TBL_W'(5);
    @(negedge clk); bus.start = 1'b1;
    @(posedge clk); #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    #2 r = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", bus.busy); else passed++;
    total++; if (bus.valid !== 1'b0) $display("FAIL abort_valid: got %b expected 0", bus.valid); else passed++;
    total++; if (bus.y !== '0) $display("FAIL abort_y: got %h expected 0", bus.y); else passed++;
    @(negedge clk); r = 1'b1;
    run_conv(bn, vn, lat, ys);
    total++; if (lat !== 9) $display("FAIL abort_restart_latency: got %0d expected 9", lat); else passed++;
    total++; if (vn !== 1) $display("FAIL abort_restart_valids: got %0d expected 1", vn); else passed++;
    total++; if (ys !== Y_NEG5) $display("FAIL abort_restart_y: got %0d expected -5", $signed(ys)); else passed++;
  endtask

  initial begin
    test_reset();
    test_zero_window();
    test_sign_tap();
    test_bit0_addr();
    test_sign_bit();
    test_start_in_run();
    test_back_to_back();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
